// File: rtl/stack_controller.sv
// stack_controller: sequences single-cycle Push/Pop requests into timed
// accesses on an asynchronous RAM port, tracking the stack pointer and the
// full/empty status.
//
// Handshake: Push/Pop are single-cycle requests. They are sampled only while
// Busy is low. A request is either accepted (Busy rises next cycle) or
// rejected (Error pulses next cycle). Requests made while Busy is high are
// ignored. Valid pulses for one cycle when DataOut changes.
module stack_controller #(
    parameter int DW    = 8,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Push,
    input  logic          Pop,
    input  logic [DW-1:0] DataIn,
    output logic [DW-1:0] DataOut,
    output logic          Valid,
    output logic          Busy,
    output logic          Full,
    output logic          Empty,
    output logic          Error,
    inout  wire  [DW-1:0] MemIO,
    output logic [AW-1:0] MemAddr,
    output logic          MemRWS,
    output logic          MemCS,
    output logic [2:0]    DbgState
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WSET  = 3'd1,
        S_WSTB  = 3'd2,
        S_WHOLD = 3'd3,
        S_RSET  = 3'd4,
        S_RSMP  = 3'd5
    } state_e;

    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   sp_m1;
    logic          full, empty;
    logic          drive_en;

    assign full  = (sp_q == SP_FULL);
    assign empty = (sp_q == '0);
    assign sp_m1 = sp_q - (AW+1)'(1);

    // State register; reset forces IDLE so MemCS drops asynchronously.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; push has priority over pop, a full push drops the pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Push && !full) begin
                    state_d = S_WSET;
                end else if (!Push && Pop && !empty) begin
                    state_d = S_RSET;
                end
            end
            S_WSET:  state_d = S_WSTB;
            S_WSTB:  state_d = S_WHOLD;
            S_WHOLD: state_d = S_IDLE;
            S_RSET:  state_d = S_RSMP;
            S_RSMP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; RWS is constant across every CS-high window.
    always_comb begin
        MemCS    = 1'b0;
        MemRWS   = 1'b0;
        Busy     = (state_q != S_IDLE);
        case (state_q)
            S_WSET:  MemRWS = 1'b1;
            S_WSTB:  begin MemRWS = 1'b1; MemCS = 1'b1; end
            S_WHOLD: MemRWS = 1'b1;
            S_RSET:  MemCS  = 1'b1;
            S_RSMP:  MemCS  = 1'b1;
            default: begin MemCS = 1'b0; MemRWS = 1'b0; end
        endcase
    end

    // The controller only drives the bus while in a write state.
    assign drive_en = MemRWS;
    assign MemIO    = drive_en ? wdata_q : {DW{1'bz}};

    assign DataOut  = dout_q;
    assign Valid    = valid_q;
    assign Error    = error_q;
    assign Full     = full;
    assign Empty    = empty;
    assign MemAddr  = addr_q;
    assign DbgState = state_q;

    // Datapath next values: request capture, pointer update, read capture.
    always_comb begin
        sp_d    = sp_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Push) begin
                    if (!full) begin
                        wdata_d = DataIn;
                        addr_d  = sp_q[AW-1:0];
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (Pop) begin
                    if (!empty) begin
                        addr_d = sp_m1[AW-1:0];
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_WHOLD: sp_d = sp_q + (AW+1)'(1);
            S_RSMP: begin
                sp_d    = sp_m1;
                dout_d  = MemIO;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sp_q    <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

endmodule
